// File: rtl/serial_load_controller.sv
// serial_load_controller: samples an asynchronous bit-serial link and
// downloads a length-prefixed program into instruction memory.
module serial_load_controller #(
    parameter int ADDR_W         = 12,
    parameter int DEPTH          = 4096,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_req,
    input  logic              dataOnPin,
    input  logic              dataPin,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_data,
    output logic              proc_hold,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   words_loaded
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        HEADER,
        LOAD,
        WRITE,
        DONE,
        ERROR
    } state_t;

    state_t state;

    logic              strb_s1;
    logic              strb_s2;
    logic              strb_prev;
    logic              data_s1;
    logic              data_s2;
    logic [30:0]       shift;
    logic [4:0]        bit_cnt;
    logic [TW-1:0]     idle_cnt;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W:0]   len;

    logic              active;
    logic              counting;
    logic              bit_edge;
    logic              word_done;
    logic              timeout;
    logic [31:0]       word;
    logic [ADDR_W:0]   next_count;
    logic              bad_len;

    // The incoming bit completes the word in place, so only 31 bits of
    // history need to be stored.
    assign active     = (state == HEADER) || (state == LOAD) ||
                        (state == WRITE);
    assign counting   = (state == HEADER) || (state == LOAD);
    assign bit_edge   = strb_s2 & ~strb_prev;
    assign word       = {data_s2, shift};
    assign word_done  = active && bit_edge && (bit_cnt == 5'd31);
    assign timeout    = counting && !bit_edge && (bit_cnt != 5'd0) &&
                        (idle_cnt == TO_LAST);
    assign next_count = words_loaded + 1'b1;
    assign bad_len    = (|word[31:ADDR_W+1]) ||
                        (word[ADDR_W:0] > DEPTH_L);

    // Two-flop synchronizers for strobe and data, plus strobe history.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            strb_s1   <= 1'b0;
            strb_s2   <= 1'b0;
            strb_prev <= 1'b0;
            data_s1   <= 1'b0;
            data_s2   <= 1'b0;
        end else begin
            strb_s1   <= dataOnPin;
            strb_s2   <= strb_s1;
            strb_prev <= strb_s2;
            data_s1   <= dataPin;
            data_s2   <= data_s1;
        end
    end

    // LSB-first shifter; held empty whenever no session is running.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shift   <= '0;
            bit_cnt <= '0;
        end else if (!active) begin
            shift   <= '0;
            bit_cnt <= '0;
        end else if (bit_edge) begin
            shift   <= word[31:1];
            bit_cnt <= bit_cnt + 5'd1;
        end
    end

    // Inter-bit idle timer, only armed while a word is partially received.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idle_cnt <= '0;
        end else if (!counting || bit_edge || (bit_cnt == 5'd0)) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end

    // Session sequencer with registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_data     <= '0;
            proc_hold    <= 1'b1;
            busy         <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
            words_loaded <= '0;
            addr         <= '0;
            len          <= '0;
        end else begin
            mem_we <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (load_req) begin
                        state        <= HEADER;
                        busy         <= 1'b1;
                        proc_hold    <= 1'b1;
                        done         <= 1'b0;
                        error        <= 1'b0;
                        words_loaded <= '0;
                        addr         <= '0;
                    end
                end
                HEADER: begin
                    if (!load_req || timeout ||
                        (word_done && bad_len)) begin
                        state     <= ERROR;
                        error     <= 1'b1;
                        busy      <= 1'b0;
                        proc_hold <= 1'b1;
                    end else if (word_done) begin
                        len <= word[ADDR_W:0];
                        if (word[ADDR_W:0] == '0) begin
                            state     <= DONE;
                            done      <= 1'b1;
                            busy      <= 1'b0;
                            proc_hold <= 1'b0;
                        end else begin
                            state <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    if (!load_req || timeout) begin
                        state     <= ERROR;
                        error     <= 1'b1;
                        busy      <= 1'b0;
                        proc_hold <= 1'b1;
                    end else if (word_done) begin
                        state    <= WRITE;
                        mem_we   <= 1'b1;
                        mem_addr <= addr;
                        mem_data <= word;
                    end
                end
                WRITE: begin
                    addr         <= addr + 1'b1;
                    words_loaded <= next_count;
                    if (!load_req) begin
                        state     <= ERROR;
                        error     <= 1'b1;
                        busy      <= 1'b0;
                        proc_hold <= 1'b1;
                    end else if (next_count == len) begin
                        state     <= DONE;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        proc_hold <= 1'b0;
                    end else begin
                        state <= LOAD;
                    end
                end
                DONE: begin
                    if (!load_req) begin
                        state <= IDLE;
                    end
                end
                ERROR: begin
                    if (!load_req) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
